// File: rtl/serial_alu_seq.sv
// Bit-serial ALU controller: feeds one operand bit per clock, LSB first, through a
// 1-bit ALU slice with the ripple carry held in a flop between cycles.
module serial_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned IdxW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // 1-bit ALU slice: ctl = {ainvert, binvert, op[1:0]}
    logic       ainvert, binvert, in1, in2, carry_in, less;
    logic [1:0] slice_op;
    logic       x, y, slice_sum, slice_cout, slice_res;

    always_comb begin
        ainvert  = ctl_q[3];
        binvert  = ctl_q[2];
        // SLT runs the subtract; the set bit is formed from the MSB afterwards
        slice_op = (ctl_q[1:0] == 2'b11) ? 2'b10 : ctl_q[1:0];
        in1      = a_q[idx_q];
        in2      = b_q[idx_q];
        carry_in = carry_q;
        less     = 1'b0;

        x          = in1 ^ ainvert;
        y          = in2 ^ binvert;
        slice_sum  = x ^ y ^ carry_in;
        slice_cout = (x & y) | (x & carry_in) | (y & carry_in);
        unique case (slice_op)
            2'b00:   slice_res = x & y;
            2'b01:   slice_res = x | y;
            2'b10:   slice_res = slice_sum;
            default: slice_res = less;
        endcase
    end

    logic last_bit, accept, msb_ovf;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctl_d    = ctl_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        last_bit = (idx_q == IdxW'(WIDTH - 1));
        accept   = start && (state_q != StRun);
        // At the MSB the carry flop holds that bit's carry-in
        msb_ovf  = carry_q ^ slice_cout;

        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_d      = a;
            b_d      = b;
            ctl_d    = alu_ctl;
            carry_d  = alu_ctl[2];
            idx_d    = '0;
            result_d = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == StRun) begin
            result_d[idx_q] = slice_res;
            carry_d         = slice_cout;
            idx_d           = idx_q + IdxW'(1);
            if (last_bit) begin
                if (ctl_q[1]) begin
                    cout_d = slice_cout;
                    ovf_d  = msb_ovf;
                    if (ctl_q[0]) begin
                        result_d    = '0;
                        result_d[0] = slice_sum ^ msb_ovf;
                    end
                end else begin
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            ctl_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctl_q    <= ctl_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: directed and random operations checked against an
// arithmetic reference model, plus start-ignore, back-to-back and mid-run reset.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   alu_ctl;
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // Reference: whole-word arithmetic on the (optionally inverted) operands
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [3:0] ctl, output logic [W-1:0] r,
                                  output logic co, output logic ov);
        logic [W-1:0] x, y;
        logic [W:0]   full;
        x = ctl[3] ? ~ma : ma;
        y = ctl[2] ? ~mb : mb;
        co = 1'b0;
        ov = 1'b0;
        case (ctl[1:0])
            2'd0: r = x & y;
            2'd1: r = x | y;
            default: begin
                full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ctl[2]};
                r  = full[W-1:0];
                co = full[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
                if (ctl[1:0] == 2'd3) r = {{(W-1){1'b0}}, r[W-1] ^ ov};
            end
        endcase
    endfunction

    // Drives one accepted operation from a ready state; returns outputs at done and
    // the number of edges after the accepting edge until done appeared.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] tc,
                          output logic [W-1:0] r, output logic co, output logic ov,
                          output logic z, output int cyc);
        start = 1'b1; a = ta; b = tb_; alu_ctl = tc;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < W + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = result; co = carry_out; ov = overflow; z = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; alu_ctl = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset busy/done: got %b want 00", {busy, done});
        end
        n_cmp++; if (result !== 8'h00) begin
            n_err++; $display("FAIL reset result: got %h want 00", result);
        end
        n_cmp++; if ({carry_out, overflow, zero} !== 3'b001) begin
            n_err++; $display("FAIL reset flags: got %b want 001", {carry_out, overflow, zero});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[7] = '{8'hF0, 8'hFF, 8'h80, 8'h0F, 8'h80, 8'h05, 8'h7F};
        logic [W-1:0] vb[7] = '{8'h3C, 8'h01, 8'h01, 8'hF0, 8'h01, 8'h03, 8'h01};
        logic [3:0]   vc[7] = '{4'b0000, 4'b0010, 4'b0110, 4'b1100, 4'b0111, 4'b0111, 4'b0010};
        logic [W-1:0] r, er;
        logic         co, ov, z, eco, eov;
        int           cyc;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vc[i], r, co, ov, z, cyc);
            model(va[i], vb[i], vc[i], er, eco, eov);
            n_cmp++; if (cyc !== W) begin
                n_err++; $display("FAIL dir[%0d] latency: got %0d want %0d", i, cyc, W);
            end
            n_cmp++; if (r !== er) begin
                n_err++; $display("FAIL dir[%0d] result: got %h want %h", i, r, er);
            end
            n_cmp++; if ({co, ov, z} !== {eco, eov, er == '0}) begin
                n_err++; $display("FAIL dir[%0d] flags c/v/z: got %b want %b", i, {co, ov, z},
                                  {eco, eov, er == '0});
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] edges[5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};
        logic [W-1:0] ra, rb, r, er;
        logic [3:0]   rc;
        logic         co, ov, z, eco, eov;
        int           cyc;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = edges[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = edges[$urandom_range(0, 4)];
            run_op(ra, rb, rc, r, co, ov, z, cyc);
            model(ra, rb, rc, er, eco, eov);
            n_cmp++; if (r !== er || {co, ov, z} !== {eco, eov, er == '0} || cyc !== W) begin
                n_err++;
                $display("FAIL rand[%0d] a=%h b=%h ctl=%b: got r=%h cvz=%b lat=%0d want r=%h cvz=%b lat=%0d",
                         i, ra, rb, rc, r, {co, ov, z}, cyc, er, {eco, eov, er == '0}, W);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] er;
        logic         eco, eov;
        int           d0, cyc;
        d0 = done_cnt;
        start = 1'b1; a = 8'h12; b = 8'h34; alu_ctl = 4'b0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; a = 8'hAA; b = 8'h55; alu_ctl = 4'b0001;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 4;
        while (!done && cyc < W + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        model(8'h12, 8'h34, 4'b0010, er, eco, eov);
        n_cmp++; if (result !== er || cyc !== W) begin
            n_err++; $display("FAIL ignore_start: got r=%h lat=%0d want r=%h lat=%0d",
                              result, cyc, er, W);
        end
        repeat (W + 3) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL ignore_start done count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er1, er2;
        logic         c1, v1, c2, v2;
        int           d0, cyc;
        d0 = done_cnt;
        model(8'h80, 8'h01, 4'b0110, er1, c1, v1);
        model(8'h05, 8'h03, 4'b0111, er2, c2, v2);
        start = 1'b1; a = 8'h80; b = 8'h01; alu_ctl = 4'b0110;
        @(posedge clk); #1;
        a = 8'h05; b = 8'h03; alu_ctl = 4'b0111;
        cyc = 0;
        while (!done && cyc < W + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++; if (result !== er1 || {carry_out, overflow} !== {c1, v1} || cyc !== W) begin
            n_err++; $display("FAIL b2b first: got r=%h cv=%b lat=%0d want r=%h cv=%b lat=%0d",
                              result, {carry_out, overflow}, cyc, er1, {c1, v1}, W);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b10) begin
            n_err++; $display("FAIL b2b no bubble busy/done: got %b want 10", {busy, done});
        end
        cyc = 0;
        while (!done && cyc < W + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++; if (result !== er2 || zero !== (er2 == '0) || cyc !== W) begin
            n_err++; $display("FAIL b2b second: got r=%h z=%b lat=%0d want r=%h z=%b lat=%0d",
                              result, zero, cyc, er2, er2 == '0, W);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt - d0 !== 2) begin
            n_err++; $display("FAIL b2b done count: got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r;
        logic         co, ov, z;
        int           d0, cyc;
        start = 1'b1; a = 8'hFF; b = 8'hFF; alu_ctl = 4'b0010;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, done, result, carry_out, overflow, zero} !== {2'b00, 8'h00, 3'b001}) begin
            n_err++; $display("FAIL midrun reset outputs: got bdrcvz=%b%b%h%b%b%b want 00 00 001",
                              busy, done, result, carry_out, overflow, zero);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt !== d0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrun no done: got dones=%0d busy=%b want 0 0",
                              done_cnt - d0, busy);
        end
        run_op(8'h12, 8'h34, 4'b0010, r, co, ov, z, cyc);
        n_cmp++; if (r !== 8'h46 || {co, ov, z} !== 3'b000 || cyc !== W) begin
            n_err++; $display("FAIL midrun recover: got r=%h cvz=%b lat=%0d want r=46 cvz=000 lat=%0d",
                              r, {co, ov, z}, cyc, W);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
